// File: rtl/adc_pipe_stage_model.sv
// Behavioural pipelined 1.5-bit/stage ADC with a flash last stage and an expected-code tap.
// Optional per-sample threshold offset enabled by macro ADC_PIPE_MODEL_OFFSET_EN.
module adc_pipe_stage_model #(
  parameter int NUM_BITS           = 3,
  parameter int NUM_BITS_PER_STAGE = 2,
  parameter int REDUNDANCY         = 1,
  parameter int BITS_ADC_STAGE     = 1,
  parameter int RES_BITS           = 8,
  localparam int NUM_STAGES = (NUM_BITS - BITS_ADC_STAGE) / (NUM_BITS_PER_STAGE - REDUNDANCY)
) (
  input  logic                                     clock_i,
  input  logic                                     reset_i,
  input  logic [RES_BITS-1:0]                      sample_i,
  input  logic                                     sample_valid_i,
  output logic                                     sample_ready_o,
  input  logic                                     flush_i,
`ifdef ADC_PIPE_MODEL_OFFSET_EN
  input  logic signed [RES_BITS-2:0]               thr_offset_i,
`endif
  output logic [NUM_BITS_PER_STAGE*NUM_STAGES-1:0] d_stage_o,
  output logic [BITS_ADC_STAGE-1:0]                d_last_stage_o,
  output logic [NUM_STAGES:0]                      stage_valid_o,
  output logic [NUM_BITS-1:0]                      exp_code_o,
  output logic                                     exp_valid_o,
  output logic                                     busy_o,
  output logic                                     flush_done_o
);

  localparam int FS = 1 << RES_BITS;
  localparam int SW = RES_BITS + 2;
  typedef logic signed [SW-1:0] sw_t;
  localparam sw_t OFF_MAX = sw_t'(FS / 8);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [NUM_BITS_PER_STAGE-1:0] stage_code(
    input logic [RES_BITS-1:0] r,
    input sw_t                 off
  );
    sw_t rs;
    sw_t t1;
    sw_t t2;
    rs = sw_t'({2'b00, r});
    t1 = sw_t'((3 * FS) / 8) + off;
    t2 = sw_t'((5 * FS) / 8) + off;
    if (rs < t1) begin
      stage_code = NUM_BITS_PER_STAGE'(0);
    end else if (rs < t2) begin
      stage_code = NUM_BITS_PER_STAGE'(1);
    end else begin
      stage_code = NUM_BITS_PER_STAGE'(2);
    end
  endfunction

  // The thresholds keep 2r - c*FS/2 inside [0,FS), so truncation to RES_BITS is lossless.
  function automatic logic [RES_BITS-1:0] stage_res(
    input logic [RES_BITS-1:0]           r,
    input logic [NUM_BITS_PER_STAGE-1:0] c
  );
    stage_res = RES_BITS'((sw_t'({2'b00, r}) <<< 1) - sw_t'(c) * sw_t'(FS / 2));
  endfunction

  state_t                        state_q;
  logic                          flush_done_q;
  logic                          accept_s;
  logic                          inflight_s;
  sw_t                           off_sat_s;

  logic [NUM_BITS_PER_STAGE-1:0] code_q [NUM_STAGES];
  logic [NUM_BITS_PER_STAGE-1:0] code_d [NUM_STAGES];
  logic [RES_BITS-1:0]           res_q  [NUM_STAGES];
  logic [RES_BITS-1:0]           res_d  [NUM_STAGES];
  logic                          val_q  [NUM_STAGES];
  logic                          val_d  [NUM_STAGES];
  sw_t                           off_q  [NUM_STAGES];
  sw_t                           off_d  [NUM_STAGES];
  logic [NUM_BITS-1:0]           tag_q  [NUM_STAGES];
  logic [NUM_BITS-1:0]           tag_d  [NUM_STAGES];

  logic [BITS_ADC_STAGE-1:0]     last_code_q, last_code_d;
  logic                          last_val_q, last_val_d;
  logic [NUM_BITS-1:0]           last_tag_q, last_tag_d;
  logic [NUM_BITS-1:0]           exp_code_q, exp_code_d;
  logic                          exp_val_q, exp_val_d;

  assign sample_ready_o = !reset_i && (state_q != ST_DRAIN);
  assign accept_s       = sample_valid_i && sample_ready_o;

`ifdef ADC_PIPE_MODEL_OFFSET_EN
  always_comb begin
    off_sat_s = sw_t'(thr_offset_i);
    if (off_sat_s > OFF_MAX) begin
      off_sat_s = OFF_MAX;
    end else if (off_sat_s < -OFF_MAX) begin
      off_sat_s = -OFF_MAX;
    end else begin
      off_sat_s = sw_t'(thr_offset_i);
    end
  end
`else
  assign off_sat_s = '0;
`endif

  // Empty slots carry zero code/residue/tag so idle fields read as 0.
  always_comb begin
    val_d[0]  = accept_s;
    code_d[0] = accept_s ? stage_code(sample_i, off_sat_s) : '0;
    res_d[0]  = accept_s ? stage_res(sample_i, code_d[0]) : '0;
    off_d[0]  = accept_s ? off_sat_s : '0;
    tag_d[0]  = accept_s ? sample_i[RES_BITS-1 -: NUM_BITS] : '0;
    for (int k = 1; k < NUM_STAGES; k++) begin
      val_d[k]  = val_q[k-1];
      code_d[k] = val_q[k-1] ? stage_code(res_q[k-1], off_q[k-1]) : '0;
      res_d[k]  = val_q[k-1] ? stage_res(res_q[k-1], code_d[k]) : '0;
      off_d[k]  = val_q[k-1] ? off_q[k-1] : '0;
      tag_d[k]  = val_q[k-1] ? tag_q[k-1] : '0;
    end
    last_val_d  = val_q[NUM_STAGES-1];
    last_code_d = val_q[NUM_STAGES-1] ? res_q[NUM_STAGES-1][RES_BITS-1 -: BITS_ADC_STAGE] : '0;
    last_tag_d  = val_q[NUM_STAGES-1] ? tag_q[NUM_STAGES-1] : '0;
    exp_val_d   = last_val_q;
    exp_code_d  = last_val_q ? last_tag_q : '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        code_q[k] <= '0;
        res_q[k]  <= '0;
        val_q[k]  <= 1'b0;
        off_q[k]  <= '0;
        tag_q[k]  <= '0;
      end
      last_code_q <= '0;
      last_val_q  <= 1'b0;
      last_tag_q  <= '0;
      exp_code_q  <= '0;
      exp_val_q   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        code_q[k] <= code_d[k];
        res_q[k]  <= res_d[k];
        val_q[k]  <= val_d[k];
        off_q[k]  <= off_d[k];
        tag_q[k]  <= tag_d[k];
      end
      last_code_q <= last_code_d;
      last_val_q  <= last_val_d;
      last_tag_q  <= last_tag_d;
      exp_code_q  <= exp_code_d;
      exp_val_q   <= exp_val_d;
    end
  end

  always_comb begin
    d_stage_o     = '0;
    stage_valid_o = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      d_stage_o[k*NUM_BITS_PER_STAGE +: NUM_BITS_PER_STAGE] = code_q[k];
      stage_valid_o[k] = val_q[k];
    end
    stage_valid_o[NUM_STAGES] = last_val_q;
  end

  assign inflight_s     = |stage_valid_o;
  assign d_last_stage_o = last_code_q;
  assign exp_code_o     = exp_code_q;
  assign exp_valid_o    = exp_val_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign flush_done_o   = flush_done_q;

  // Control FSM; flush_i is only honoured outside DRAIN.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      flush_done_q <= 1'b0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flush_i) begin
            state_q <= ST_DRAIN;
          end else if (accept_s) begin
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          if (flush_i) begin
            state_q <= ST_DRAIN;
          end else if (!accept_s && !inflight_s) begin
            state_q <= ST_IDLE;
          end else begin
            state_q <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (!inflight_s) begin
            state_q      <= ST_IDLE;
            flush_done_q <= 1'b1;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_pipe_stage_model.sv
// Scoreboard bench for adc_pipe_stage_model: arithmetic reference model feeds per-stage queues.
module tb_adc_pipe_stage_model;
  localparam int RB = 8;
  localparam int NB = 3;
  localparam int NS = 2;
  localparam int FS = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic                 svalid = 1'b0;
  logic                 flush = 1'b0;
  logic [RB-1:0]        smp = '0;
  logic signed [RB-2:0] toff = '0;
  logic                 sample_ready_o;
  logic [2*NS-1:0]      d_stage_o;
  logic [0:0]           d_last_stage_o;
  logic [NS:0]          stage_valid_o;
  logic [NB-1:0]        exp_code_o;
  logic                 exp_valid_o;
  logic                 busy_o;
  logic                 flush_done_o;

  adc_pipe_stage_model dut (
    .clock_i        (clk),
    .reset_i        (rst),
    .sample_i       (smp),
    .sample_valid_i (svalid),
    .sample_ready_o (sample_ready_o),
    .flush_i        (flush),
`ifdef ADC_PIPE_MODEL_OFFSET_EN
    .thr_offset_i   (toff),
`endif
    .d_stage_o      (d_stage_o),
    .d_last_stage_o (d_last_stage_o),
    .stage_valid_o  (stage_valid_o),
    .exp_code_o     (exp_code_o),
    .exp_valid_o    (exp_valid_o),
    .busy_o         (busy_o),
    .flush_done_o   (flush_done_o)
  );

  typedef struct {
    int code;
    int due;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  ent_t ql[$];
  ent_t qe[$];
  int cyc = 0;
  int n_pass = 0;
  int n_tot = 0;
  int done_cnt = 0;

  function void check(input string nm, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, req, cyc);
  endfunction

  // Reference: apply the stage decision rule with plain integer arithmetic.
  task automatic push(input int s, input int o);
    int r;
    int c;
    int off;
    ent_t e;
    off = 0;
`ifdef ADC_PIPE_MODEL_OFFSET_EN
    off = (o > FS / 8) ? FS / 8 : (o < -FS / 8) ? -FS / 8 : o;
`endif
    r = s;
    for (int k = 0; k < NS; k++) begin
      if (r < (3 * FS) / 8 + off) c = 0;
      else if (r < (5 * FS) / 8 + off) c = 1;
      else c = 2;
      e.code = c;
      e.due = cyc + k;
      if (k == 0) q0.push_back(e);
      else q1.push_back(e);
      r = 2 * r - c * (FS / 2);
    end
    e.code = r / (FS / 2);
    e.due = cyc + NS;
    ql.push_back(e);
    e.code = s / (FS / (1 << NB));
    e.due = cyc + NS + 1;
    qe.push_back(e);
  endtask

  task automatic step(input logic v, input int s, input logic f, input logic r, input int o);
    logic acc;
    @(negedge clk);
    svalid = v;
    smp = s[RB-1:0];
    flush = f;
    rst = r;
    toff = o[RB-2:0];
    #1;
    acc = v && sample_ready_o;
    @(posedge clk);
    cyc++;
    if (r) begin
      q0.delete();
      q1.delete();
      ql.delete();
      qe.delete();
    end else if (acc) begin
      push(s, o);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0);
  endtask

  task automatic mon(input string nm, input logic v, input int code, ref ent_t q[$]);
    ent_t e;
    if (v) begin
      if (q.size() == 0) begin
        check({nm, " unexpected valid"}, 1, 0);
      end else begin
        e = q.pop_front();
        check({nm, " code"}, code, e.code);
        check({nm, " latency"}, cyc, e.due);
      end
    end else begin
      check({nm, " idle code"}, code, 0);
    end
  endtask

  always @(negedge clk) begin
    mon("stage0", stage_valid_o[0], int'(d_stage_o[1:0]), q0);
    mon("stage1", stage_valid_o[1], int'(d_stage_o[3:2]), q1);
    mon("last", stage_valid_o[2], int'(d_last_stage_o), ql);
    mon("exp", exp_valid_o, int'(exp_code_o), qe);
    if (flush_done_o) done_cnt++;
  end

  initial begin
    step(1'b0, 0, 1'b0, 1'b1, 0);
    step(1'b1, 5, 1'b0, 1'b1, 0);
    #2;
    check("reset ready", int'(sample_ready_o), 0);
    check("reset valids", int'(stage_valid_o), 0);
    check("reset busy", int'(busy_o), 0);
    check("reset exp_valid", int'(exp_valid_o), 0);
    step(1'b0, 0, 1'b0, 1'b0, 0);
    #2;
    check("ready after reset", int'(sample_ready_o), 1);

    step(1'b1, 77, 1'b0, 1'b0, 0);
    idle(6);
    step(1'b1, 179, 1'b0, 1'b0, 0);
    idle(6);
    step(1'b1, 0, 1'b0, 1'b0, 0);
    step(1'b1, 255, 1'b0, 1'b0, 0);
    idle(6);
    check("idle after stream", int'(busy_o), 0);

    // Flush with two samples in flight; extra flush and offered sample during DRAIN are ignored.
    step(1'b1, 10, 1'b0, 1'b0, 0);
    step(1'b1, 200, 1'b0, 1'b0, 0);
    step(1'b0, 0, 1'b1, 1'b0, 0);
    #2;
    check("drain ready", int'(sample_ready_o), 0);
    check("drain busy", int'(busy_o), 1);
    step(1'b1, 50, 1'b1, 1'b0, 0);
    for (int i = 0; i < 20 && done_cnt == 0; i++) idle(1);
    idle(4);
    check("flush_done pulses", done_cnt, 1);
    check("idle after drain", int'(busy_o), 0);

    // Accept together with flush: the sample must still be delivered.
    step(1'b1, 99, 1'b1, 1'b0, 0);
    for (int i = 0; i < 20 && done_cnt == 1; i++) idle(1);
    idle(4);
    check("flush_done accept+flush", done_cnt, 2);

    // Empty drain exits on the next edge.
    step(1'b0, 0, 1'b1, 1'b0, 0);
    #2;
    check("empty drain busy", int'(busy_o), 1);
    idle(1);
    #2;
    check("empty drain done", int'(flush_done_o), 1);
    check("empty drain idle", int'(busy_o), 0);
    idle(2);

    // Reset two cycles after accept discards the sample.
    step(1'b1, 123, 1'b0, 1'b0, 0);
    idle(1);
    step(1'b0, 0, 1'b0, 1'b1, 0);
    #2;
    check("mid reset valids", int'(stage_valid_o), 0);
    check("mid reset stage codes", int'(d_stage_o), 0);
    check("mid reset exp", int'(exp_valid_o), 0);
    check("mid reset busy", int'(busy_o), 0);
    idle(6);

`ifdef ADC_PIPE_MODEL_OFFSET_EN
    step(1'b1, 120, 1'b0, 1'b0, 40);
    idle(6);
    step(1'b1, 120, 1'b0, 1'b0, -40);
    idle(6);
`endif

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
           int'($urandom_range(0, 127)) - 64);
    end
    idle(10);
    check("scoreboard empty", q0.size() + q1.size() + ql.size() + qe.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/adc_pipe_stage_model.md
ADC_PIPE_STAGE_MODEL -- requirements
Module: adc_pipe_stage_model

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_BITS, 3, final ADC code width.
- NUM_BITS_PER_STAGE, 2, code width per 1.5-bit stage; only 2 is supported.
- REDUNDANCY, 1, redundant bits per stage; only 1 is supported.
- BITS_ADC_STAGE, 1, last flash stage code width.
- RES_BITS, 8, input sample width; must be at least NUM_BITS+3.

REQ-002 Derived values SHALL be NUM_STAGES = (NUM_BITS-BITS_ADC_STAGE)/(NUM_BITS_PER_STAGE-REDUNDANCY) and FS = 2^RES_BITS.

REQ-003 The ports SHALL be (name, direction, width, meaning):
- clock_i, in, 1, the only clock.
- reset_i, in, 1, synchronous, active-high.
- sample_i, in, RES_BITS, unsigned input voltage in LSBs of FS.
- sample_valid_i, in, 1, sample offered.
- sample_ready_o, out, 1, sample accepted when high together with sample_valid_i.
- flush_i, in, 1, request to drain the pipeline.
- d_stage_o, out, NUM_BITS_PER_STAGE*NUM_STAGES, field k is the stage-k code.
- d_last_stage_o, out, BITS_ADC_STAGE, flash stage code.
- stage_valid_o, out, NUM_STAGES+1, bit k qualifies stage k; bit NUM_STAGES qualifies the last stage.
- exp_code_o, out, NUM_BITS, expected encoder result.
- exp_valid_o, out, 1, qualifies exp_code_o.
- busy_o, out, 1, FSM is not IDLE.
- flush_done_o, out, 1, one-cycle pulse when a drain completes.

Function
REQ-004 A sample SHALL be accepted on a rising clock_i edge with sample_valid_i=1 and sample_ready_o=1.

REQ-005 Stage 0 SHALL register code c and residue r' from r=sample_i on the accepting edge; stage k SHALL register from stage k-1 one edge later.

REQ-006 Each 1.5-bit stage SHALL produce c=0 if r<T1, c=1 if T1<=r<T2, else c=2, with T1=3FS/8+off and T2=5FS/8+off.

REQ-007 The residue SHALL be r' = 2r - c*FS/2, computed in RES_BITS+2 bits, always in [0,FS), and stored in RES_BITS bits.

REQ-008 The last stage SHALL produce code = r >> (RES_BITS-BITS_ADC_STAGE), registered one edge after stage NUM_STAGES-1.

REQ-009 Stage-k code SHALL be valid k+1 cycles after the accepting edge; the last-stage code SHALL be valid NUM_STAGES+1 cycles after it.

REQ-010 exp_code_o SHALL equal the accepted sample >> (RES_BITS-NUM_BITS), with exp_valid_o asserted NUM_STAGES+2 cycles after acceptance.

REQ-011 Any slot not holding a valid sample SHALL drive its code 0 and its valid bit 0; back-to-back samples SHALL stream at one per cycle.

REQ-012 The FSM SHALL have states IDLE, RUN and DRAIN:
- IDLE->RUN on accept.
- RUN->IDLE when nothing is in flight and there is no accept.
- IDLE or RUN ->DRAIN on flush_i.
- DRAIN->IDLE when all valid bits are 0, pulsing flush_done_o for one cycle.

REQ-013 sample_ready_o SHALL be 0 in DRAIN and while reset_i=1, and 1 otherwise.

REQ-014 A sample accepted in the same cycle as flush_i SHALL be drained and delivered.

REQ-015 flush_i SHALL be ignored while in DRAIN.

REQ-016 DRAIN entered with an empty pipeline SHALL exit on the next edge.

Reset
REQ-017 While reset_i=1 at an edge, all pipeline registers, codes, valids, exp_code_o, exp_valid_o and flush_done_o SHALL clear to 0 and the FSM SHALL enter IDLE.

REQ-018 Reset asserted mid-operation SHALL discard all in-flight samples with no partial outputs.

Configuration
REQ-019 With macro ADC_PIPE_MODEL_OFFSET_EN defined:
- An input thr_offset_i (signed, RES_BITS-1 bits) SHALL exist.
- It SHALL be saturated to ±FS/8 and registered on accept, giving off for that sample in every stage.
- exp_code_o SHALL be unchanged, since redundancy corrects the offset.

REQ-020 Without ADC_PIPE_MODEL_OFFSET_EN, the thr_offset_i port SHALL be absent and off SHALL be 0.

Verification
REQ-021 The bench SHALL cover these directed scenarios (RES_BITS=8, defaults):
- sample 77 -> stage codes 0, 1; last 1; exp_code_o 2, exp_valid_o 4 cycles after acceptance.
- sample 179 -> codes 2, 1; last 0; exp 5.
- back-to-back 0 then 255 -> codes 0,0,last 0,exp 0, then next cycle codes 2,2,last 1,exp 7; no bubble.
- flush_i with 2 samples in flight -> ready 0; both exps delivered; flush_done_o pulses once; FSM returns to IDLE.
- reset_i asserted 2 cycles after accept -> no exp_valid_o; all outputs 0 next cycle.
- OFFSET_EN, thr_offset_i=+40 (clamped to 32), sample 120 -> codes 0, 2; last 1; exp 3.
